// File: rtl/test_result_monitor.sv
// Observes register-file writes from a CPU under test, shadows the done/pass/test-number
// registers and turns them into a settled pass/fail verdict, guarded by a cycle watchdog.
module test_result_monitor #(
    parameter int DONE_REG       = 26,
    parameter int PASS_REG       = 27,
    parameter int TNUM_REG       = 3,
    parameter int SETTLE_CYCLES  = 10,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [4:0]       wr_addr,
    input  logic [31:0]      wr_data,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [31:0]      fail_testnum,
    output logic [CNT_W-1:0] cycle_count,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;

    localparam logic [4:0]       DONE_A      = 5'(DONE_REG);
    localparam logic [4:0]       PASS_A      = 5'(PASS_REG);
    localparam logic [4:0]       TNUM_A      = 5'(TNUM_REG);
    localparam logic [31:0]      SETTLE_LOAD = 32'(SETTLE_CYCLES);
    localparam bit               WD_EN       = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] WD_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    logic [31:0]      done_sh_r;
    logic [31:0]      pass_sh_r;
    logic [31:0]      tnum_sh_r;
    logic [31:0]      settle_cnt_r;
    logic [CNT_W-1:0] cycle_count_r;
    logic [31:0]      fail_testnum_r;
    logic             done_r;
    logic             pass_r;
    logic             fail_r;
    logic             timeout_r;

    logic             wr_valid_s;
    logic             done_go_s;
    logic             wd_hit_s;
    logic             counting_s;
    logic             cnt_max_s;

    // Address 0 is the hard-wired zero register, so writes to it never reach a shadow.
    assign wr_valid_s = wr_en && (wr_addr != 5'd0);
    assign done_go_s  = wr_valid_s && (wr_addr == DONE_A) && (wr_data == 32'h0000_0001);
    assign wd_hit_s   = WD_EN && (cycle_count_r == WD_LAST);
    assign counting_s = (state_r == ST_RUN) || (state_r == ST_SETTLE);
    assign cnt_max_s  = &cycle_count_r;

    // Shadow copies of the observed registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_sh_r <= 32'd0;
            pass_sh_r <= 32'd0;
            tnum_sh_r <= 32'd0;
        end else if (clr) begin
            done_sh_r <= 32'd0;
            pass_sh_r <= 32'd0;
            tnum_sh_r <= 32'd0;
        end else if (wr_valid_s) begin
            if (wr_addr == DONE_A) done_sh_r <= wr_data;
            if (wr_addr == PASS_A) pass_sh_r <= wr_data;
            if (wr_addr == TNUM_A) tnum_sh_r <= wr_data;
        end
    end

    // Verdict FSM with its counters and registered flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_RUN;
            settle_cnt_r   <= 32'd0;
            cycle_count_r  <= '0;
            fail_testnum_r <= 32'd0;
            done_r         <= 1'b0;
            pass_r         <= 1'b0;
            fail_r         <= 1'b0;
            timeout_r      <= 1'b0;
        end else if (clr) begin
            state_r        <= ST_RUN;
            settle_cnt_r   <= 32'd0;
            cycle_count_r  <= '0;
            fail_testnum_r <= 32'd0;
            done_r         <= 1'b0;
            pass_r         <= 1'b0;
            fail_r         <= 1'b0;
            timeout_r      <= 1'b0;
        end else begin
            if (counting_s && !cnt_max_s) begin
                cycle_count_r <= cycle_count_r + CNT_ONE;
            end
            case (state_r)
                ST_RUN: begin
                    // A done write on the watchdog's last edge still wins.
                    if (done_go_s) begin
                        state_r      <= ST_SETTLE;
                        settle_cnt_r <= SETTLE_LOAD;
                    end else if (wd_hit_s) begin
                        state_r   <= ST_TIMEOUT;
                        timeout_r <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_r != 32'd0) begin
                        settle_cnt_r <= settle_cnt_r - 32'd1;
                    end else if (pass_sh_r == 32'd1) begin
                        state_r <= ST_PASS;
                        done_r  <= 1'b1;
                        pass_r  <= 1'b1;
                    end else begin
                        state_r        <= ST_FAIL;
                        done_r         <= 1'b1;
                        fail_r         <= 1'b1;
                        fail_testnum_r <= tnum_sh_r;
                    end
                end
                ST_PASS, ST_FAIL, ST_TIMEOUT: begin
                    state_r <= state_r;
                end
                default: begin
                    state_r <= ST_RUN;
                end
            endcase
        end
    end

    assign done         = done_r;
    assign pass         = pass_r;
    assign fail         = fail_r;
    assign timeout      = timeout_r;
    assign fail_testnum = fail_testnum_r;
    assign cycle_count  = cycle_count_r;
    assign state        = state_r;

endmodule

// File: tb/tb_test_result_monitor.sv
// Vector-table bench for test_result_monitor: expected outputs are queued with each
// stimulus cycle and compared one clock later; reset and alias cases are hand-written.
module tb_test_result_monitor;

    localparam logic [2:0] RUN = 3'd0, SET = 3'd1, PAS = 3'd2, FAI = 3'd3, TMO = 3'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = 5'd0;
    logic [31:0] wr_data = 32'd0;

    logic        done, pass, fail, timeout;
    logic [31:0] fail_testnum, cycle_count;
    logic [2:0]  state;

    logic        z_done, z_pass, z_fail, z_timeout;
    logic [31:0] z_fail_testnum, z_cycle_count;
    logic [2:0]  z_state;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        c;
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
        logic [2:0]  st;
        logic        dn, ps, fl, to;
        logic [31:0] ftn;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    test_result_monitor #(.TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .fail_testnum(fail_testnum), .cycle_count(cycle_count), .state(state)
    );

    // Second instance whose done register aliases the zero register.
    test_result_monitor #(.DONE_REG(0)) dut_z (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .done(z_done), .pass(z_pass), .fail(z_fail), .timeout(z_timeout),
        .fail_testnum(z_fail_testnum), .cycle_count(z_cycle_count), .state(z_state)
    );

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic c, input logic we, input logic [4:0] a, input logic [31:0] d,
                       input logic [2:0] st, input logic dn, input logic ps, input logic fl,
                       input logic to, input logic [31:0] ftn, input logic [31:0] cnt);
        vec_t v;
        v.c = c; v.we = we; v.a = a; v.d = d; v.st = st;
        v.dn = dn; v.ps = ps; v.fl = fl; v.to = to; v.ftn = ftn; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    task automatic idle(input logic [2:0] st, input logic [31:0] cnt);
        add(1'b0, 1'b0, 5'd0, 32'd0, st, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, cnt);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [2:0] st, input logic [31:0] cnt);
        add(1'b0, 1'b1, a, d, st, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, cnt);
    endtask

    task automatic rearm();
        add(1'b1, 1'b0, 5'd0, 32'd0, RUN, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        // Sequence A: pass verdict lands 11 edges after the done write.
        rearm();
        wr(5'd27, 32'd1, RUN, 32'd1);
        wr(5'd26, 32'd1, SET, 32'd2);
        for (int k = 1; k <= 10; k++) idle(SET, 32'(2 + k));
        add(1'b0, 1'b0, 5'd0, 32'd0, PAS, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd13);
        add(1'b0, 1'b0, 5'd0, 32'd0, PAS, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd13);
        // Sequence B: fail with test number 5; the clr also leaves PASS.
        rearm();
        idle(RUN, 32'd1);
        wr(5'd3, 32'd5, RUN, 32'd2);
        wr(5'd27, 32'd0, RUN, 32'd3);
        wr(5'd26, 32'd1, SET, 32'd4);
        for (int k = 1; k <= 10; k++) idle(SET, 32'(4 + k));
        add(1'b0, 1'b0, 5'd0, 32'd0, FAI, 1'b1, 1'b0, 1'b1, 1'b0, 32'd5, 32'd15);
        add(1'b0, 1'b1, 5'd27, 32'd1, FAI, 1'b1, 1'b0, 1'b1, 1'b0, 32'd5, 32'd15);
        // Sequence C: pass flag written three edges after done still counts.
        rearm();
        wr(5'd27, 32'd0, RUN, 32'd1);
        wr(5'd26, 32'd1, SET, 32'd2);
        idle(SET, 32'd3);
        idle(SET, 32'd4);
        wr(5'd27, 32'd1, SET, 32'd5);
        for (int k = 1; k <= 7; k++) idle(SET, 32'(5 + k));
        add(1'b0, 1'b0, 5'd0, 32'd0, PAS, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd13);
        // Sequence D: pass flag and test number written on the verdict edge are ignored.
        rearm();
        wr(5'd3, 32'd7, RUN, 32'd1);
        wr(5'd27, 32'd0, RUN, 32'd2);
        wr(5'd26, 32'd1, SET, 32'd3);
        for (int k = 1; k <= 10; k++) idle(SET, 32'(3 + k));
        add(1'b0, 1'b1, 5'd27, 32'd1, FAI, 1'b1, 1'b0, 1'b1, 1'b0, 32'd7, 32'd14);
        add(1'b0, 1'b1, 5'd3, 32'd9, FAI, 1'b1, 1'b0, 1'b1, 1'b0, 32'd7, 32'd14);
        // Sequence E: non-qualifying done writes, addr 0, and a done rewrite inside SETTLE.
        rearm();
        wr(5'd26, 32'd2, RUN, 32'd1);
        wr(5'd0, 32'd1, RUN, 32'd2);
        add(1'b0, 1'b0, 5'd26, 32'd1, RUN, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd3);
        wr(5'd26, 32'd1, SET, 32'd4);
        wr(5'd26, 32'd0, SET, 32'd5);
        for (int k = 1; k <= 9; k++) idle(SET, 32'(5 + k));
        add(1'b0, 1'b0, 5'd0, 32'd0, FAI, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 32'd15);
        // Sequence F: watchdog fires on edge 50 and the count freezes there.
        rearm();
        for (int k = 1; k <= 49; k++) idle(RUN, 32'(k));
        add(1'b0, 1'b0, 5'd0, 32'd0, TMO, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd50);
        add(1'b0, 1'b1, 5'd26, 32'd1, TMO, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd50);
        // Sequence G: a done write on edge 50 beats the watchdog, which stays quiet in SETTLE.
        rearm();
        for (int k = 1; k <= 49; k++) idle(RUN, 32'(k));
        wr(5'd26, 32'd1, SET, 32'd50);
        for (int k = 1; k <= 10; k++) idle(SET, 32'(50 + k));
        add(1'b0, 1'b0, 5'd0, 32'd0, FAI, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 32'd61);

        // Asynchronous reset state before any clock edge.
        #1;
        check("rst_state", 0, 32'(state), 32'(RUN));
        check("rst_done", 0, 32'(done), 32'd0);
        check("rst_cnt", 0, cycle_count, 32'd0);
        check("rst_ftn", 0, fail_testnum, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            clr = tbl[i].c; wr_en = tbl[i].we; wr_addr = tbl[i].a; wr_data = tbl[i].d;
            exp_q.push_back(tbl[i]);
            @(negedge clk);
            begin
                vec_t e;
                e = exp_q.pop_front();
                check("state", i, 32'(state), 32'(e.st));
                check("done", i, 32'(done), 32'(e.dn));
                check("pass", i, 32'(pass), 32'(e.ps));
                check("fail", i, 32'(fail), 32'(e.fl));
                check("timeout", i, 32'(timeout), 32'(e.to));
                check("fail_testnum", i, fail_testnum, e.ftn);
                check("cycle_count", i, cycle_count, e.cnt);
                check("alias_state", i, 32'(z_state), 32'(RUN));
            end
        end

        // Reset arriving mid-SETTLE clears everything without a clock edge.
        clr = 1'b1; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
        @(negedge clk);
        clr = 1'b0; wr_en = 1'b1; wr_addr = 5'd26; wr_data = 32'd1;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_state", 0, 32'(state), 32'(SET));
        check("pre_rst_cnt", 0, cycle_count, 32'd4);
        #2 rst = 1'b1;
        #1;
        check("async_rst_state", 0, 32'(state), 32'(RUN));
        check("async_rst_cnt", 0, cycle_count, 32'd0);
        check("async_rst_flags", 0, 32'({done, pass, fail, timeout}), 32'd0);
        check("async_rst_ftn", 0, fail_testnum, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("post_rst_state", 0, 32'(state), 32'(RUN));
        check("post_rst_cnt", 0, cycle_count, 32'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
